// File: rtl/ext_r_burst_buffer.sv
// AXI R-channel elastic buffer with a registered output (1 cycle minimum latency), either cut-through or store-and-forward.
// Upstream ready depends only on fill level; downstream valid/payload hold until the beat is popped.
module ext_r_burst_buffer #(
    parameter int ID_WIDTH      = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int USER_WIDTH    = 6,
    parameter int DEPTH         = 4,
    parameter int STORE_AND_FWD = 0,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [1:0]            slave_resp_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [1:0]            master_resp_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i,
    output logic [CNT_W-1:0]      fill_level_o,
    output logic [CNT_W-1:0]      bursts_o,
    output logic                  forced_rel_o
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BEAT_W = ID_WIDTH + USER_WIDTH + DATA_WIDTH + 3;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "ext_r_burst_buffer: DEPTH must be a power of 2 and >= 2");
    end

    logic [BEAT_W-1:0] mem [DEPTH];
    logic [BEAT_W-1:0] head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fill;
    logic [CNT_W-1:0]  bursts;
    logic              rel;
    logic              valid;
    logic              push;
    logic              pop;
    logic              push_last;
    logic              pop_last;
    logic              force_rel;

    assign head = mem[rd_ptr];
    assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = head;

    assign slave_ready_o  = (fill != CNT_W'(DEPTH));
    assign master_valid_o = valid;
    assign fill_level_o   = fill;
    assign bursts_o       = bursts;
    assign forced_rel_o   = force_rel;

    // A full buffer holding no last beat can never complete a burst: open the gate once.
    assign force_rel = (STORE_AND_FWD != 0) && (fill == CNT_W'(DEPTH)) && (bursts == '0) && !rel;

    always_comb begin
        valid = (fill != '0);
        if (STORE_AND_FWD != 0) begin
            valid = (fill != '0) && ((bursts != '0) || rel || force_rel);
        end
    end

    assign push      = slave_valid_i && slave_ready_o;
    assign pop       = valid && master_ready_i;
    assign push_last = push && slave_last_i;
    assign pop_last  = pop && master_last_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            bursts <= '0;
            rel    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase
            bursts <= bursts + CNT_W'(push_last) - CNT_W'(pop_last);
            // Stays open (even through empty) until the oversized burst's last beat leaves.
            rel    <= (rel || force_rel) && !pop_last;
        end
    end
endmodule

// File: tb/tb_ext_r_burst_buffer.sv
// Bench for ext_r_burst_buffer: three instances (cut-through D4, store-and-forward D4 and D8) share one stimulus stream.
// A queue-based model predicts every output each cycle; tables and short scripts cover the corner cases.
module tb_ext_r_burst_buffer;
    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  r;
        logic [5:0]  u;
        logic [3:0]  id;
        logic        l;
    } beat_t;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        r;
        logic        e_sr;
        logic        e_mv;
        logic [63:0] e_d;
        int          e_fill;
        int          e_b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        s_vld = 1'b0;
    logic        s_last = 1'b0;
    logic        m_rdy = 1'b0;
    logic [63:0] s_dat = '0;
    logic [1:0]  s_resp = '0;
    logic [5:0]  s_user = '0;
    logic [3:0]  s_id = '0;

    logic        sr [3];
    logic        mv [3];
    logic        ml [3];
    logic        fr [3];
    logic [63:0] md [3];
    logic [1:0]  mr [3];
    logic [5:0]  mu [3];
    logic [3:0]  mi [3];
    logic [2:0]  fl0, bu0, fl1, bu1;
    logic [3:0]  fl2, bu2;
    logic [3:0]  fl [3];
    logic [3:0]  bu [3];

    assign fl[0] = {1'b0, fl0};
    assign fl[1] = {1'b0, fl1};
    assign fl[2] = fl2;
    assign bu[0] = {1'b0, bu0};
    assign bu[1] = {1'b0, bu1};
    assign bu[2] = bu2;

    ext_r_burst_buffer #(.DEPTH(4), .STORE_AND_FWD(0)) u_ct4 (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_vld), .slave_data_i(s_dat), .slave_resp_i(s_resp),
        .slave_user_i(s_user), .slave_id_i(s_id), .slave_last_i(s_last),
        .slave_ready_o(sr[0]),
        .master_valid_o(mv[0]), .master_data_o(md[0]), .master_resp_o(mr[0]),
        .master_user_o(mu[0]), .master_id_o(mi[0]), .master_last_o(ml[0]),
        .master_ready_i(m_rdy),
        .fill_level_o(fl0), .bursts_o(bu0), .forced_rel_o(fr[0])
    );

    ext_r_burst_buffer #(.DEPTH(4), .STORE_AND_FWD(1)) u_sf4 (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_vld), .slave_data_i(s_dat), .slave_resp_i(s_resp),
        .slave_user_i(s_user), .slave_id_i(s_id), .slave_last_i(s_last),
        .slave_ready_o(sr[1]),
        .master_valid_o(mv[1]), .master_data_o(md[1]), .master_resp_o(mr[1]),
        .master_user_o(mu[1]), .master_id_o(mi[1]), .master_last_o(ml[1]),
        .master_ready_i(m_rdy),
        .fill_level_o(fl1), .bursts_o(bu1), .forced_rel_o(fr[1])
    );

    ext_r_burst_buffer #(.DEPTH(8), .STORE_AND_FWD(1)) u_sf8 (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_vld), .slave_data_i(s_dat), .slave_resp_i(s_resp),
        .slave_user_i(s_user), .slave_id_i(s_id), .slave_last_i(s_last),
        .slave_ready_o(sr[2]),
        .master_valid_o(mv[2]), .master_data_o(md[2]), .master_resp_o(mr[2]),
        .master_user_o(mu[2]), .master_id_o(mi[2]), .master_last_o(ml[2]),
        .master_ready_i(m_rdy),
        .fill_level_o(fl2), .bursts_o(bu2), .forced_rel_o(fr[2])
    );

    // Reference model: a queue of stored beats per instance plus the forced-release flag.
    beat_t mq [3][$];
    bit    rel [3];
    int    dep [3] = '{4, 4, 8};
    int    saf [3] = '{0, 1, 1};
    int    vectors = 0;
    int    miscompares = 0;
    vec_t  tbl [15];

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Called just after a falling edge: check all outputs, then advance the model across the rising edge.
    task automatic tick();
        int    n;
        int    b;
        bit    frc;
        bit    ev;
        bit    erdy;
        bit    push [3];
        bit    pop [3];
        bit    nrel [3];
        beat_t nb;
        for (int k = 0; k < 3; k++) begin
            n = mq[k].size();
            b = 0;
            for (int i = 0; i < n; i++) if (mq[k][i].l) b++;
            frc  = (saf[k] != 0) && (n == dep[k]) && (b == 0) && !rel[k];
            ev   = (n != 0) && ((saf[k] == 0) || (b != 0) || rel[k] || frc);
            erdy = (n != dep[k]);
            chk("slave_ready", k, 64'(sr[k]), 64'(erdy));
            chk("master_valid", k, 64'(mv[k]), 64'(ev));
            chk("fill_level", k, 64'(fl[k]), 64'(n));
            chk("bursts", k, 64'(bu[k]), 64'(b));
            chk("forced_rel", k, 64'(fr[k]), 64'(frc));
            if (ev) begin
                chk("data", k, md[k], mq[k][0].d);
                chk("resp", k, 64'(mr[k]), 64'(mq[k][0].r));
                chk("user", k, 64'(mu[k]), 64'(mq[k][0].u));
                chk("id", k, 64'(mi[k]), 64'(mq[k][0].id));
                chk("last", k, 64'(ml[k]), 64'(mq[k][0].l));
            end
            push[k] = s_vld && erdy;
            pop[k]  = ev && m_rdy;
            nrel[k] = (rel[k] || frc) && !(pop[k] && mq[k][0].l);
        end
        nb = '{d: s_dat, r: s_resp, u: s_user, id: s_id, l: s_last};
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mq[k].delete();
                rel[k] = 1'b0;
            end else begin
                if (pop[k]) void'(mq[k].pop_front());
                if (push[k]) mq[k].push_back(nb);
                rel[k] = nrel[k];
            end
        end
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        tick();
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input bit l, input bit r);
        s_vld  = v;
        s_dat  = d;
        s_last = l;
        m_rdy  = r;
        s_resp = d[1:0];
        s_user = d[7:2];
        s_id   = d[11:8];
    endtask

    task automatic do_reset();
        drive(0, 64'h0, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        bit adv;
        int i;

        // {valid, data, last, ready | ready, valid, data, fill, bursts} for the cut-through D4 instance
        tbl[0]  = '{1, 64'hA5, 1, 0, 1, 0, 64'h0,  0, 0};
        tbl[1]  = '{0, 64'h0,  0, 0, 1, 1, 64'hA5, 1, 1};
        tbl[2]  = '{0, 64'h0,  0, 1, 1, 1, 64'hA5, 1, 1};
        tbl[3]  = '{0, 64'h0,  0, 0, 1, 0, 64'h0,  0, 0};
        tbl[4]  = '{1, 64'h1,  0, 0, 1, 0, 64'h0,  0, 0};
        tbl[5]  = '{1, 64'h2,  0, 0, 1, 1, 64'h1,  1, 0};
        tbl[6]  = '{1, 64'h3,  0, 0, 1, 1, 64'h1,  2, 0};
        tbl[7]  = '{1, 64'h4,  0, 0, 1, 1, 64'h1,  3, 0};
        tbl[8]  = '{1, 64'h5,  1, 0, 0, 1, 64'h1,  4, 0};
        tbl[9]  = '{1, 64'h5,  1, 1, 0, 1, 64'h1,  4, 0};
        tbl[10] = '{1, 64'h5,  1, 1, 1, 1, 64'h2,  3, 0};
        tbl[11] = '{0, 64'h0,  0, 1, 1, 1, 64'h3,  3, 1};
        tbl[12] = '{0, 64'h0,  0, 1, 1, 1, 64'h4,  2, 1};
        tbl[13] = '{0, 64'h0,  0, 1, 1, 1, 64'h5,  1, 1};
        tbl[14] = '{0, 64'h0,  0, 0, 1, 0, 64'h0,  0, 0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single beat latency, then fill to capacity with backpressure and drain in order.
        for (int t = 0; t < 15; t++) begin
            drive(tbl[t].v, tbl[t].d, tbl[t].l, tbl[t].r);
            @(negedge clk);
            chk("tbl_ready", t, 64'(sr[0]), 64'(tbl[t].e_sr));
            chk("tbl_valid", t, 64'(mv[0]), 64'(tbl[t].e_mv));
            chk("tbl_fill", t, 64'(fl[0]), 64'(tbl[t].e_fill));
            chk("tbl_bursts", t, 64'(bu[0]), 64'(tbl[t].e_b));
            if (tbl[t].e_mv) chk("tbl_data", t, md[0], tbl[t].e_d);
            tick();
        end

        // Store-and-forward D8: gapped 3-beat burst is withheld until its last beat is stored.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'h30 + 64'(k), k == 2, 1);
            @(negedge clk);
            chk("saf_hold", 2, 64'(mv[2]), 64'h0);
            tick();
            if (k < 2) begin
                repeat (2) begin
                    drive(0, 64'h0, 0, 1);
                    @(negedge clk);
                    chk("saf_hold", 2, 64'(mv[2]), 64'h0);
                    tick();
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 64'h0, 0, 1);
            @(negedge clk);
            chk("saf_release", 2, 64'(mv[2]), 64'h1);
            chk("saf_order", 2, md[2], 64'h30 + 64'(k));
            chk("saf_last", 2, 64'(ml[2]), 64'(k == 2));
            tick();
        end
        @(negedge clk);
        chk("saf_bursts_done", 2, 64'(bu[2]), 64'h0);
        chk("saf_empty", 2, 64'(mv[2]), 64'h0);
        tick();

        // Store-and-forward D4: a 6-beat burst must trigger the forced release exactly once.
        do_reset();
        i = 0;
        for (int c = 0; c < 14; c++) begin
            drive(i < 6, 64'h40 + 64'(i), i == 5, c >= 5);
            @(negedge clk);
            if (c == 3) begin
                chk("frc_before", 1, 64'(fr[1]), 64'h0);
                chk("frc_hold", 1, 64'(mv[1]), 64'h0);
            end
            if (c == 4) begin
                chk("frc_pulse", 1, 64'(fr[1]), 64'h1);
                chk("frc_valid", 1, 64'(mv[1]), 64'h1);
                chk("frc_fill", 1, 64'(fl[1]), 64'h4);
            end
            if (c == 5) begin
                chk("frc_once", 1, 64'(fr[1]), 64'h0);
                chk("frc_latched", 1, 64'(mv[1]), 64'h1);
                chk("frc_head", 1, md[1], 64'h40);
            end
            adv = s_vld && sr[1];
            tick();
            if (adv) i++;
        end
        drive(1, 64'h50, 0, 1);
        cyc();
        drive(0, 64'h0, 0, 1);
        @(negedge clk);
        chk("rel_cleared", 1, 64'(mv[1]), 64'h0);
        chk("rel_cleared_fill", 1, 64'(fl[1]), 64'h1);
        tick();
        drive(1, 64'h51, 1, 1);
        cyc();
        drive(0, 64'h0, 0, 1);
        repeat (4) cyc();

        // Reset with three beats stored discards them; a fresh burst follows cleanly.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'h60 + 64'(k), 0, 0);
            cyc();
        end
        drive(0, 64'h0, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("pre_rst_fill", k, 64'(fl[k]), 64'h3);
        tick();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_fill", k, 64'(fl[k]), 64'h0);
            chk("rst_bursts", k, 64'(bu[k]), 64'h0);
            chk("rst_valid", k, 64'(mv[k]), 64'h0);
            chk("rst_ready", k, 64'(sr[k]), 64'h1);
        end
        tick();
        drive(1, 64'h70, 0, 1);
        cyc();
        drive(1, 64'h71, 1, 1);
        cyc();
        drive(0, 64'h0, 0, 1);
        repeat (4) cyc();

        // Random traffic against the model.
        for (int c = 0; c < 1200; c++) begin
            s_vld  = ($urandom % 2) == 0;
            s_dat  = {$urandom, $urandom};
            s_last = ($urandom % 4) == 0;
            s_resp = 2'($urandom);
            s_user = 6'($urandom);
            s_id   = 4'($urandom);
            m_rdy  = ($urandom % 2) == 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
